// File: rtl/calc2_top.sv
// ---------------------------------------------------------------------------
// calc2_top -- multi-channel two-operand calculator with one shared ALU.
//
// Each channel runs its own small FSM (IDLE -> OP2 -> WAIT -> RESP -> IDLE).
//   IDLE : a nonzero cmd latches cmd and operand1.
//   OP2  : the operand bus is latched as operand2; the cmd bus is ignored.
//   WAIT : the channel waits for the round-robin arbiter to select it.
//   RESP : response code and result are shown for exactly one cycle.
// Arbitration is registered: a WAIT channel is selected at one edge and its
// result is computed by the shared ALU and registered at the next edge (the
// grant edge), where the channel enters RESP. Uncontended, a cmd sampled at
// edge k therefore responds in the cycle after edge k+3.
//
// Commands: 1 add, 2 subtract, 5 shift left, 6 logical shift right;
// any other nonzero cmd responds "invalid" with data 0.
// Response codes: 00 none, 01 success, 10 overflow/underflow, 11 invalid.
//
// Ports
//   c_clk        in   clock, all state updates on the rising edge
//   reset        in   synchronous active-low reset
//   req_cmd_in   in   NUM_CH x 4-bit commands, channel i at [4i+3:4i]
//   req_data_in  in   NUM_CH x DATA_W operands, channel i in slice i
//   req_tag_in   in   NUM_CH x 2-bit tags (only with CALC2_TAG_EN)
//   out_tag      out  NUM_CH x 2-bit tag echo in RESP (only with CALC2_TAG_EN)
//   out_resp     out  NUM_CH x 2-bit response code
//   out_data     out  NUM_CH x DATA_W result, qualified by out_resp
//   out_busy     out  NUM_CH flags, channel not IDLE
//
// Configuration macro: CALC2_TAG_EN adds the request tag echo path.
// ---------------------------------------------------------------------------
module calc2_top #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
) (
  input  logic                     c_clk,
  input  logic                     reset,
  input  logic [NUM_CH*4-1:0]      req_cmd_in,
  input  logic [NUM_CH*DATA_W-1:0] req_data_in,
`ifdef CALC2_TAG_EN
  input  logic [NUM_CH*2-1:0]      req_tag_in,
  output logic [NUM_CH*2-1:0]      out_tag,
`endif
  output logic [NUM_CH*2-1:0]      out_resp,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_busy
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  typedef enum logic [1:0] {IDLE, OP2, WAIT, RESP} state_t;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_OK   = 2'b01,
    RESP_OVF  = 2'b10,
    RESP_INV  = 2'b11
  } resp_t;

  // Per-channel state
  state_t            state_q [NUM_CH];
  logic [3:0]        cmd_q   [NUM_CH];
  logic [DATA_W-1:0] op1_q   [NUM_CH];
  logic [DATA_W-1:0] op2_q   [NUM_CH];
  resp_t             resp_q  [NUM_CH];
  logic [DATA_W-1:0] data_q  [NUM_CH];
  logic [NUM_CH-1:0] busy_q;
`ifdef CALC2_TAG_EN
  logic [1:0]        tag_q     [NUM_CH];
  logic [1:0]        tag_out_q [NUM_CH];
`endif

  // Arbiter: selection register feeding the shared ALU, and round-robin pointer
  logic              sel_vld_q;
  logic [IDX_W-1:0]  sel_idx_q;
  logic [IDX_W-1:0]  ptr_q;

  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W:0]    cand_idx;

  // Round-robin search starting at ptr_q. The loop runs from the farthest
  // offset down so the nearest eligible channel is the last one written.
  // The channel selected last cycle is still in WAIT this cycle and must not
  // be picked twice.
  // NOTE: every output of an always_comb gets a default before any branch;
  // a path that leaves a variable unassigned would infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      cand_idx = {1'b0, ptr_q} + (IDX_W+1)'(off);
      if (cand_idx >= (IDX_W+1)'(NUM_CH)) begin
        cand_idx = cand_idx - (IDX_W+1)'(NUM_CH);
      end
      if (state_q[cand_idx[IDX_W-1:0]] == WAIT &&
          !(sel_vld_q && sel_idx_q == cand_idx[IDX_W-1:0])) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx[IDX_W-1:0];
      end
    end
  end

  // Shared ALU, operating on the operands of the selected channel
  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W:0]   alu_sum;
  resp_t             alu_resp;
  logic [DATA_W-1:0] alu_data;

  always_comb begin
    alu_cmd  = cmd_q[sel_idx_q];
    alu_a    = op1_q[sel_idx_q];
    alu_b    = op2_q[sel_idx_q];
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    alu_resp = RESP_INV;
    alu_data = '0;
    case (alu_cmd)
      CMD_ADD: begin
        if (alu_sum[DATA_W]) begin
          alu_resp = RESP_OVF;
        end else begin
          alu_resp = RESP_OK;
          alu_data = alu_sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (alu_a < alu_b) begin
          alu_resp = RESP_OVF;
        end else begin
          alu_resp = RESP_OK;
          alu_data = alu_a - alu_b;
        end
      end
      CMD_SHL: begin
        alu_resp = RESP_OK;
        alu_data = alu_a << alu_b[SHAMT_W-1:0];
      end
      CMD_SHR: begin
        alu_resp = RESP_OK;
        alu_data = alu_a >> alu_b[SHAMT_W-1:0];
      end
      default: begin
        alu_resp = RESP_INV;
        alu_data = '0;
      end
    endcase
  end

  // Channel FSMs and arbiter state.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values from before this edge.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      sel_vld_q <= 1'b0;
      sel_idx_q <= '0;
      ptr_q     <= '0;
      busy_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        resp_q[i]  <= RESP_NONE;
        data_q[i]  <= '0;
        // NOTE: the operand/command holding registers are cleared too; they
        // are few and small, and it keeps every transaction free of history.
        cmd_q[i]   <= '0;
        op1_q[i]   <= '0;
        op2_q[i]   <= '0;
`ifdef CALC2_TAG_EN
        tag_q[i]     <= '0;
        tag_out_q[i] <= '0;
`endif
      end
    end else begin
      sel_vld_q <= grant_vld;
      if (grant_vld) begin
        sel_idx_q <= grant_idx;
        ptr_q     <= (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
      end

      for (int i = 0; i < NUM_CH; i++) begin
        // Response outputs are single-cycle pulses; cleared unless entering RESP.
        resp_q[i] <= RESP_NONE;
        data_q[i] <= '0;
`ifdef CALC2_TAG_EN
        tag_out_q[i] <= '0;
`endif
        case (state_q[i])
          IDLE: begin
            if (req_cmd_in[4*i +: 4] != 4'd0) begin
              cmd_q[i]   <= req_cmd_in[4*i +: 4];
              op1_q[i]   <= req_data_in[i*DATA_W +: DATA_W];
`ifdef CALC2_TAG_EN
              tag_q[i]   <= req_tag_in[2*i +: 2];
`endif
              state_q[i] <= OP2;
              busy_q[i]  <= 1'b1;
            end
          end
          OP2: begin
            op2_q[i]   <= req_data_in[i*DATA_W +: DATA_W];
            state_q[i] <= WAIT;
          end
          WAIT: begin
            if (sel_vld_q && sel_idx_q == IDX_W'(i)) begin
              resp_q[i]  <= alu_resp;
              data_q[i]  <= alu_data;
`ifdef CALC2_TAG_EN
              tag_out_q[i] <= tag_q[i];
`endif
              state_q[i] <= RESP;
            end
          end
          RESP: begin
            state_q[i] <= IDLE;
            busy_q[i]  <= 1'b0;
          end
          default: begin
            state_q[i] <= IDLE;
            busy_q[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pack per-channel registers onto the flat output buses
  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign out_resp[2*g +: 2]           = resp_q[g];
    assign out_data[g*DATA_W +: DATA_W] = data_q[g];
`ifdef CALC2_TAG_EN
    assign out_tag[2*g +: 2]            = tag_out_q[g];
`endif
  end

  assign out_busy = busy_q;

endmodule

// File: tb/tb_calc2_top.sv
// ---------------------------------------------------------------------------
// tb_calc2_top -- self-checking bench for calc2_top (NUM_CH=4, DATA_W=32).
//
// A transaction-timeline model tracks, per channel, the edge a request was
// accepted and the edge the arbiter selected it; responses, busy flags and
// results follow from those edge numbers and plain arithmetic. Directed
// steps cover the documented scenarios with literal expected values, then a
// randomized phase exercises arbitration, dropped commands and resets.
// ---------------------------------------------------------------------------
module tb_calc2_top;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int CW     = NUM_CH * 4;
  localparam int DW     = NUM_CH * DATA_W;
  localparam int TW     = NUM_CH * 2;

  logic          c_clk = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] req_cmd_in  = '0;
  logic [DW-1:0] req_data_in = '0;
  logic [TW-1:0] req_tag_in  = '0;
  logic [TW-1:0] out_tag;
  logic [TW-1:0] out_resp;
  logic [DW-1:0] out_data;
  logic [NUM_CH-1:0] out_busy;

  calc2_top #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
`ifdef CALC2_TAG_EN
    .req_tag_in  (req_tag_in),
    .out_tag     (out_tag),
`endif
    .out_resp    (out_resp),
    .out_data    (out_data),
    .out_busy    (out_busy)
  );

  always #5 c_clk = ~c_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one pending transaction per channel
  bit                m_occ [NUM_CH];
  bit                m_sel [NUM_CH];
  int                m_acc [NUM_CH];
  int                m_gnt [NUM_CH];
  logic [3:0]        m_cmd [NUM_CH];
  logic [DATA_W-1:0] m_op1 [NUM_CH];
  logic [DATA_W-1:0] m_op2 [NUM_CH];
  logic [1:0]        m_tag [NUM_CH];
  int                m_ptr  = 0;
  int                edge_n = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic void ref_result(input logic [3:0] c, input logic [DATA_W-1:0] x,
                                     input logic [DATA_W-1:0] y,
                                     output logic [1:0] r, output logic [DATA_W-1:0] d);
    longint unsigned wide;
    int amt;
    amt = int'(y % DATA_W);
    r = 2'b11;
    d = '0;
    case (c)
      4'd1: begin
        wide = 64'(x) + 64'(y);
        if (wide >= (64'd1 << DATA_W)) r = 2'b10;
        else begin r = 2'b01; d = DATA_W'(wide); end
      end
      4'd2: begin
        if (x < y) r = 2'b10;
        else begin r = 2'b01; d = x - y; end
      end
      4'd5: begin r = 2'b01; d = x << amt; end
      4'd6: begin r = 2'b01; d = x >> amt; end
      default: begin r = 2'b11; d = '0; end
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge
  task automatic model_edge();
    bit done;
    edge_n++;
    if (!reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        m_occ[ch] = 1'b0;
        m_sel[ch] = 1'b0;
      end
      m_ptr = 0;
      return;
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!m_occ[ch]) begin
        if (req_cmd_in[4*ch +: 4] != 4'd0) begin
          m_occ[ch] = 1'b1;
          m_sel[ch] = 1'b0;
          m_acc[ch] = edge_n;
          m_cmd[ch] = req_cmd_in[4*ch +: 4];
          m_op1[ch] = req_data_in[ch*DATA_W +: DATA_W];
          m_tag[ch] = req_tag_in[2*ch +: 2];
        end
      end else if (edge_n == m_acc[ch] + 1) begin
        m_op2[ch] = req_data_in[ch*DATA_W +: DATA_W];
      end
    end
    done = 1'b0;
    for (int off = 0; off < NUM_CH; off++) begin
      int c;
      c = (m_ptr + off) % NUM_CH;
      if (!done && m_occ[c] && !m_sel[c] && edge_n >= m_acc[c] + 2) begin
        m_sel[c] = 1'b1;
        m_gnt[c] = edge_n;
        m_ptr    = (c + 1) % NUM_CH;
        done     = 1'b1;
      end
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (m_occ[ch] && m_sel[ch] && edge_n == m_gnt[ch] + 2) m_occ[ch] = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    logic [1:0]        er;
    logic [DATA_W-1:0] ed;
    logic [1:0]        et;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      er = 2'b00;
      ed = '0;
      et = 2'b00;
      if (m_occ[ch] && m_sel[ch] && edge_n == m_gnt[ch] + 1) begin
        ref_result(m_cmd[ch], m_op1[ch], m_op2[ch], er, ed);
        et = m_tag[ch];
      end
      check($sformatf("resp ch%0d edge %0d", ch, edge_n), out_resp[2*ch +: 2], er);
      check($sformatf("data ch%0d edge %0d", ch, edge_n), out_data[ch*DATA_W +: DATA_W], ed);
      check($sformatf("busy ch%0d edge %0d", ch, edge_n), out_busy[ch], m_occ[ch]);
`ifdef CALC2_TAG_EN
      check($sformatf("tag ch%0d edge %0d", ch, edge_n), out_tag[2*ch +: 2], et);
`endif
    end
  endtask

  // Drive inputs, take one edge, update the model, then compare #1 later
  task automatic cycle(input logic rst_v, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input logic [TW-1:0] t);
    reset       = rst_v;
    req_cmd_in  = c;
    req_data_in = d;
    req_tag_in  = t;
    @(posedge c_clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b1, '0, '0, '0);
  endtask

  function automatic logic [CW-1:0] cv(input int ch, input logic [3:0] c);
    logic [CW-1:0] v;
    v = '0;
    v[4*ch +: 4] = c;
    return v;
  endfunction

  function automatic logic [DW-1:0] dv(input int ch, input logic [DATA_W-1:0] d);
    logic [DW-1:0] v;
    v = '0;
    v[ch*DATA_W +: DATA_W] = d;
    return v;
  endfunction

  function automatic logic [TW-1:0] tv(input int ch, input logic [1:0] t);
    logic [TW-1:0] v;
    v = '0;
    v[2*ch +: 2] = t;
    return v;
  endfunction

  // Hard time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [CW-1:0] rc;
    logic [DW-1:0] rd;
    logic [TW-1:0] rt;
    int r;

    // Reset state
    cycle(1'b0, '0, '0, '0);
    cycle(1'b0, '0, '0, '0);
    check("reset busy", out_busy, 0);
    check("reset resp", out_resp, 0);
    check("reset data zero", out_data == '0, 1);

    // First edge with reset high accepts: ch0 add 0x64 + 0x27
    cycle(1'b1, cv(0, 1), dv(0, 32'h64), '0);
    check("add busy k", out_busy[0], 1);
    cycle(1'b1, '0, dv(0, 32'h27), '0);
    check("add busy k+1", out_busy[0], 1);
    idle(1);
    check("add no early resp", out_resp[1:0], 2'b00);
    idle(1);
    check("add resp", out_resp[1:0], 2'b01);
    check("add data", out_data[31:0], 32'h8B);
    idle(1);
    check("add idle after", out_busy[0], 0);

    // Shifts on ch0
    cycle(1'b1, cv(0, 5), dv(0, 32'h3), '0);
    cycle(1'b1, '0, dv(0, 32'h22), '0);
    idle(2);
    check("shl resp", out_resp[1:0], 2'b01);
    check("shl data", out_data[31:0], 32'hC);
    idle(1);
    cycle(1'b1, cv(0, 6), dv(0, 32'h8000_0000), '0);
    cycle(1'b1, '0, dv(0, 32'd31), '0);
    idle(2);
    check("shr resp", out_resp[1:0], 2'b01);
    check("shr data", out_data[31:0], 32'h1);
    idle(1);

    // Overflow, underflow and invalid on ch1..ch3 together
    cycle(1'b1, cv(1, 1) | cv(2, 2) | cv(3, 3),
          dv(1, 32'hFFFF_FFFF) | dv(2, 32'h22) | dv(3, 32'h7), '0);
    cycle(1'b1, '0, dv(1, 32'h1) | dv(2, 32'h23) | dv(3, 32'h9), '0);
    idle(2);
    check("ovf resp ch1", out_resp[3:2], 2'b10);
    check("ovf data ch1", out_data[63:32], 32'h0);
    idle(1);
    check("udf resp ch2", out_resp[5:4], 2'b10);
    idle(1);
    check("inv resp ch3", out_resp[7:6], 2'b11);
    check("inv data ch3", out_data[127:96], 32'h0);
    idle(2);

    // All channels at once, two rounds; nonzero cmds in the OP2 cycle are ignored
    for (int round = 0; round < 2; round++) begin
      rd = '0;
      for (int ch = 0; ch < NUM_CH; ch++) rd |= dv(ch, 32'($urandom_range(0, 16'hFFFF)));
      cycle(1'b1, {NUM_CH{4'd1}}, rd, '0);
      rd = '0;
      for (int ch = 0; ch < NUM_CH; ch++) rd |= dv(ch, 32'($urandom_range(0, 16'hFFFF)));
      cycle(1'b1, {NUM_CH{4'd2}}, rd, '0);
      idle(1);
      for (int j = 0; j < NUM_CH; j++) begin
        idle(1);
        check($sformatf("rr order round %0d slot %0d", round, j), out_resp, 64'h1 << (2*j));
      end
      idle(1);
    end

    // Reset during a transaction on ch2
    cycle(1'b1, cv(2, 1), dv(2, 32'd10), '0);
    cycle(1'b1, '0, dv(2, 32'd20), '0);
    cycle(1'b0, '0, '0, '0);
    check("mid reset busy", out_busy, 0);
    for (int j = 0; j < 6; j++) begin
      idle(1);
      check("mid reset no resp", out_resp, 0);
    end
    cycle(1'b1, cv(2, 2), dv(2, 32'h5), '0);
    cycle(1'b1, '0, dv(2, 32'h2), '0);
    idle(2);
    check("post reset sub resp", out_resp[5:4], 2'b01);
    check("post reset sub data", out_data[95:64], 32'h3);
    idle(1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      rc = '0;
      rd = '0;
      rt = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r = int'($urandom_range(0, 9));
        case (r)
          5: rc |= cv(ch, 4'd1);
          6: rc |= cv(ch, 4'd2);
          7: rc |= cv(ch, 4'd5);
          8: rc |= cv(ch, 4'd6);
          9: rc |= cv(ch, 4'($urandom_range(1, 15)));
          default: ;
        endcase
        if ($urandom_range(0, 1) == 0) rd |= dv(ch, 32'($urandom));
        else rd |= dv(ch, 32'($urandom_range(0, 255)));
        rt |= tv(ch, 2'($urandom_range(0, 3)));
      end
      cycle(($urandom_range(0, 99) != 0), rc, rd, rt);
    end

`ifdef CALC2_TAG_EN
    // Tag echo; a second request while busy is dropped
    cycle(1'b0, '0, '0, '0);
    cycle(1'b1, cv(1, 1), dv(1, 32'h5), tv(1, 2'b10));
    cycle(1'b1, cv(1, 1), dv(1, 32'h6), tv(1, 2'b01));
    cycle(1'b1, cv(1, 1), dv(1, 32'h7), tv(1, 2'b01));
    idle(1);
    check("tag resp", out_resp[3:2], 2'b01);
    check("tag echo", out_tag[3:2], 2'b10);
    for (int j = 0; j < 4; j++) begin
      idle(1);
      check("tag single resp", out_resp[3:2], 2'b00);
    end
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
